vscale_vstore_xvec: RTL and testbench
=====================================

# vscale_vstore_xvec

Vector store serializer for the xvec extension. Sits on the far side of the vector operand path: it captures a full `XVEC_VEC_LEN`-element vector-register value and drains it, one `XPR_LEN` word per bus beat, onto the core's pipelined data-memory port (address phase followed by data phase). While it runs, the pipeline holds on `busy`; it signals completion with a one-cycle `done`.

## Interface
Parameters:
- `VEC_LEN`, default `` `XVEC_VEC_LEN ``: number of elements per vector.
- `XLEN`, default `` `XPR_LEN ``: element width in bits.
- `VL_W`, default `` `XVEC_VL_WIDTH ``: width of the element-count field (clog2(VEC_LEN+1)).

Ports (clock and reset first):
- `clk` — input, 1: single clock; all logic on the rising edge.
- `reset_n` — input, 1: reset, **synchronous, active-low**.
- `start` — input, 1: request; sampled only in IDLE.
- `base_addr` — input, 32: byte address of element 0; sampled with `start`.
- `vl` — input, VL_W: elements to store (0..VEC_LEN); sampled with `start`.
- `vec_data` — input, VEC_LEN*XLEN: element k is bits [k*XLEN +: XLEN]; sampled with `start`.
- `busy` — output, 1: unit owns the dmem port; the pipeline stalls.
- `done` — output, 1: one-cycle completion pulse.
- `err` — output, 1: valid with `done`; misaligned base.
- `dmem_en` — output, 1: address-phase valid.
- `dmem_wen` — output, 1: write; equals `dmem_en`.
- `dmem_size` — output, `` `MEM_TYPE_WIDTH ``: always `` `MEM_TYPE_W ``.
- `dmem_addr` — output, 32: address-phase address.
- `dmem_wdata` — output, XLEN: data-phase data.
- `dmem_wait` — input, 1: bus stall; freezes both phases.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 captures `vec_data`, `base_addr` and `vl` into shadow registers and clears `idx`.
  - `vl`=0: no bus traffic; `done`=1 with `err`=0 next cycle; stay in IDLE.
  - `base_addr[1:0]`≠0: no bus traffic; `done`=1 with `err`=1 next cycle; stay in IDLE.
  - Otherwise go to RUN.
- RUN:
  - Address phase: `dmem_en`=1, `dmem_addr` = base + 4*idx.
  - Data phase: `dmem_wdata` = element idx-1 whenever idx>0.
  - On a cycle with `dmem_wait`=0: idx increments. When the issued idx equals vl-1, go to DRAIN.
- DRAIN:
  - `dmem_en`=0; `dmem_wdata` = element vl-1.
  - When `dmem_wait`=0: pulse `done` (`err`=0) on the next cycle and return to IDLE.
- `dmem_wait`=1 in RUN or DRAIN: every output (`dmem_en`, `dmem_addr`, `dmem_wdata`) and the state are held unchanged.
- Address arithmetic is 32-bit modular; wrap past 0xFFFF_FFFC is not an error.
- `start` while busy is ignored; no queueing.
- Shadow registers isolate the unit from later changes on `vec_data`.
- `reset_n` low in any state, mid-transfer included: next edge forces IDLE and aborts the transfer with no `done`.

## Timing
- Reset values: `busy`, `done`, `err`, `dmem_en`, `dmem_wen` = 0; `dmem_addr`, `dmem_wdata` = 0; `dmem_size` = `` `MEM_TYPE_W `` (constant); state IDLE.
- With `start` sampled at cycle T, vl=N≥1, no waits:
  - Address phases at T+1..T+N.
  - Data phase for element k at T+2+k.
  - `busy` high T+1..T+N+1.
  - `done` at T+N+2.
- Each `dmem_wait` cycle delays all later events by one cycle.
- Error or vl=0: `done` at T+1; `busy` never rises.
- `done` and `busy` are never high together.
- A new `start` is accepted in the same cycle `done` is high (back-to-back).

## Structure
- `xvec_defines.vh` gains `XVEC_VL_WIDTH`.
- `` `XVEC_VEC_LEN `` and `` `MEM_TYPE_* `` come from the existing headers.
- State encodings are local localparams.
- Element selection (wide shadow register indexed by idx) is a natural sub-module: `vscale_vec_elem_sel_xvec` (combinational mux, VEC_LEN→1).
- Everything else is flat.

## Test plan
- vl=4, base 0x1000, elements 0xA0..0xA3, no waits → addresses 0x1000/4/8/C at T+1..T+4; wdata 0xA0..0xA3 at T+2..T+5; `done` at T+6, `err`=0.
- Same transfer with `dmem_wait` high at T+2 and T+3 → outputs frozen on those cycles; `done` at T+8; data order unchanged.
- vl=0 → no `dmem_en`; `done`=1, `err`=0 at T+1. base 0x1002 → no `dmem_en`; `done`=1, `err`=1 at T+1.
- vl=VEC_LEN, base 0xFFFF_FFF8 → addresses wrap to 0x0000_0000 onward; all VEC_LEN words written; `err`=0.
- `start` pulsed mid-RUN and `vec_data` changed after capture → ignored; written data matches the captured vector.
- `reset_n` low at T+3 of a vl=8 transfer → next cycle all outputs are at reset values; no `done`; a fresh `start` then completes normally.

Source files
------------

// File: rtl/vscale_vstore_xvec_pkg.sv
// Shared sizing constants and helpers for the xvec vector-store path.
// Stands in for the core's xvec and memory-type defines.
package vscale_vstore_xvec_pkg;

  localparam int XVEC_VEC_LEN   = 8;
  localparam int XPR_LEN        = 32;
  localparam int XVEC_VL_WIDTH  = $clog2(XVEC_VEC_LEN + 1);
  localparam int MEM_TYPE_WIDTH = 3;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W = 3'd2;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/vscale_vec_elem_sel_xvec.sv
// Picks one XLEN-wide element out of a packed vector register.
// Out-of-range selects return zero.
module vscale_vec_elem_sel_xvec #(
  parameter int VEC_LEN = 8,
  parameter int XLEN    = 32,
  parameter int SEL_W   = 4
) (
  input  logic [VEC_LEN*XLEN-1:0] vec,
  input  logic [SEL_W-1:0]        sel,
  output logic [XLEN-1:0]         elem
);

  always_comb begin
    elem = '0;
    for (int k = 0; k < VEC_LEN; k++) begin
      if (sel == SEL_W'(k)) elem = vec[k*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/vscale_vstore_xvec.sv
// Vector store serializer: drains a captured vector register onto the
// pipelined dmem port, one word per beat, then pulses done.
//
// state   | meaning
// S_IDLE  | waiting for start; reports vl=0 / misaligned completions
// S_RUN   | address phase for element idx, data phase for idx-1
// S_DRAIN | final data phase for element vl-1
module vscale_vstore_xvec
  import vscale_vstore_xvec_pkg::*;
#(
  parameter int VEC_LEN = XVEC_VEC_LEN,
  parameter int XLEN    = XPR_LEN,
  parameter int VL_W    = XVEC_VL_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [31:0]               base_addr,
  input  logic [VL_W-1:0]           vl,
  input  logic [VEC_LEN*XLEN-1:0]   vec_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      dmem_en,
  output logic                      dmem_wen,
  output logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  output logic [31:0]               dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  input  logic                      dmem_wait
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]              state;
  logic [VL_W-1:0]         idx;
  logic [VL_W-1:0]         vl_q;
  logic [VEC_LEN*XLEN-1:0] vec_q;
  logic [XLEN-1:0]         cur_elem;

  vscale_vec_elem_sel_xvec #(
    .VEC_LEN (VEC_LEN),
    .XLEN    (XLEN),
    .SEL_W   (VL_W)
  ) u_elem_sel (
    .vec  (vec_q),
    .sel  (idx),
    .elem (cur_elem)
  );

  assign dmem_wen  = dmem_en;
  assign dmem_size = MEM_TYPE_W;

  // dmem_addr doubles as the base-address shadow: it starts at base and
  // steps by one word per accepted address phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      vl_q       <= '0;
      vec_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dmem_en    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_q <= vec_data;
            vl_q  <= vl;
            idx   <= '0;
            if (vl == '0) begin
              done <= 1'b1;
            end else if (addr_misaligned(base_addr)) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state     <= S_RUN;
              busy      <= 1'b1;
              dmem_en   <= 1'b1;
              dmem_addr <= base_addr;
            end
          end
        end
        S_RUN: begin
          if (!dmem_wait) begin
            dmem_wdata <= cur_elem;
            if (idx == vl_q - VL_W'(1)) begin
              state   <= S_DRAIN;
              dmem_en <= 1'b0;
            end else begin
              idx       <= idx + VL_W'(1);
              dmem_addr <= dmem_addr + 32'd4;
            end
          end
        end
        S_DRAIN: begin
          if (!dmem_wait) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_vstore_xvec.sv
// Self-checking bench for vscale_vstore_xvec: directed scenarios plus
// randomized transfers against a transaction-level reference model.
module tb_vscale_vstore_xvec;
  import vscale_vstore_xvec_pkg::*;

  localparam int VL = XVEC_VEC_LEN;
  localparam int XW = XPR_LEN;
  localparam int VW = XVEC_VL_WIDTH;
  localparam int MAXC = 64;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      start = 1'b0;
  logic [31:0]               base_addr = '0;
  logic [VW-1:0]             vl = '0;
  logic [VL*XW-1:0]          vec_data = '0;
  logic                      dmem_wait = 1'b0;
  logic                      busy, done, err, dmem_en, dmem_wen;
  logic [MEM_TYPE_WIDTH-1:0] dmem_size;
  logic [31:0]               dmem_addr;
  logic [XW-1:0]             dmem_wdata;

  vscale_vstore_xvec dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .vl         (vl),
    .vec_data   (vec_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dmem_en    (dmem_en),
    .dmem_wen   (dmem_wen),
    .dmem_size  (dmem_size),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wait  (dmem_wait)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observations of the most recent do_xfer, indexed by cycle relative to start.
  logic [31:0]   exp_addr_q[$], obs_addr_q[$];
  logic [XW-1:0] exp_data_q[$], obs_data_q[$];
  int            done_rel, done_cnt, exp_done_rel, overlap_cnt, port_bad;
  logic          done_err;
  logic          o_en[MAXC], o_busy[MAXC], o_done[MAXC];
  logic [31:0]   o_addr[MAXC];
  logic [XW-1:0] o_wdata[MAXC];

  function automatic logic [VL*XW-1:0] rand_vec();
    logic [VL*XW-1:0] v;
    for (int k = 0; k < VL; k++) v[k*XW +: XW] = XW'($urandom);
    return v;
  endfunction

  task automatic do_xfer(input logic [31:0] b, input int n, input logic [VL*XW-1:0] v,
                         input int wait_pct, input int wa, input int wb, input int poke);
    int   progress;
    bit   pend, w, bad;
    logic [31:0] pend_addr;
    exp_addr_q.delete(); exp_data_q.delete();
    obs_addr_q.delete(); obs_data_q.delete();
    bad = (b[1:0] != 2'b00);
    if (!bad)
      for (int k = 0; k < n; k++) begin
        exp_addr_q.push_back(b + 32'(4 * k));
        exp_data_q.push_back(v[k*XW +: XW]);
      end
    exp_done_rel = (bad || n == 0) ? 1 : -1;
    progress = 0; done_cnt = 0; done_rel = -1; done_err = 1'bx;
    overlap_cnt = 0; port_bad = 0; pend = 0; pend_addr = '0;
    for (int r = 0; r < MAXC; r++) begin
      o_en[r] = 0; o_busy[r] = 0; o_done[r] = 0; o_addr[r] = '0; o_wdata[r] = '0;
    end
    start = 1'b1; base_addr = b; vl = VW'(n); vec_data = v; dmem_wait = 1'b0;
    @(negedge clk);
    o_en[0] = dmem_en; o_busy[0] = busy; o_done[0] = done;
    @(posedge clk); #1;
    start = 1'b0;
    vec_data = rand_vec();
    base_addr = $urandom;
    vl = VW'($urandom_range(1, VL));
    for (int rel = 1; rel < MAXC; rel++) begin
      w = (rel == wa) || (rel == wb) || ($urandom_range(0, 99) < wait_pct);
      dmem_wait = w;
      start = (rel == poke);
      if (start) begin
        base_addr = {$urandom_range(0, 255), 2'b00};
        vec_data = rand_vec();
      end
      // N address beats plus one drain beat must each see a non-stalled cycle.
      if (exp_done_rel < 0 && !w) begin
        progress++;
        if (progress == n + 1) exp_done_rel = rel + 1;
      end
      @(negedge clk);
      o_en[rel] = dmem_en; o_addr[rel] = dmem_addr; o_wdata[rel] = dmem_wdata;
      o_busy[rel] = busy; o_done[rel] = done;
      if (dmem_wen !== dmem_en || dmem_size !== MEM_TYPE_W) port_bad++;
      if (!w) begin
        if (pend) begin
          obs_addr_q.push_back(pend_addr);
          obs_data_q.push_back(dmem_wdata);
        end
        pend = dmem_en;
        pend_addr = dmem_addr;
      end
      if (done) begin
        done_cnt++;
        if (done_rel < 0) begin done_rel = rel; done_err = err; end
      end
      if (done && busy) overlap_cnt++;
      @(posedge clk); #1;
      if (exp_done_rel > 0 && rel >= exp_done_rel + 1) break;
    end
    dmem_wait = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, err, dmem_en, dmem_wen} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000", {busy, done, err, dmem_en, dmem_wen});
    end
    vectors++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", dmem_addr, dmem_wdata);
    end
    vectors++;
    if (dmem_size !== MEM_TYPE_W) begin
      miscompares++;
      $display("FAIL reset_size got %0d want %0d", dmem_size, MEM_TYPE_W);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [VL*XW-1:0] v;
    v = rand_vec();
    for (int k = 0; k < 4; k++) v[k*XW +: XW] = XW'(32'hA0 + k);
    do_xfer(32'h1000, 4, v, 0, -1, -1, -1);
    for (int r = 0; r <= 6; r++) begin
      vectors++;
      if (o_en[r] !== (r >= 1 && r <= 4)) begin
        miscompares++;
        $display("FAIL basic_en rel=%0d got %b want %b", r, o_en[r], (r >= 1 && r <= 4));
      end
      if (r >= 1 && r <= 4) begin
        vectors++;
        if (o_addr[r] !== 32'h1000 + 32'(4 * (r - 1))) begin
          miscompares++;
          $display("FAIL basic_addr rel=%0d got %h want %h", r, o_addr[r], 32'h1000 + 32'(4 * (r - 1)));
        end
      end
      if (r >= 2 && r <= 5) begin
        vectors++;
        if (o_wdata[r] !== XW'(32'hA0 + r - 2)) begin
          miscompares++;
          $display("FAIL basic_wdata rel=%0d got %h want %h", r, o_wdata[r], 32'hA0 + r - 2);
        end
      end
      vectors++;
      if (o_busy[r] !== (r >= 1 && r <= 5)) begin
        miscompares++;
        $display("FAIL basic_busy rel=%0d got %b want %b", r, o_busy[r], (r >= 1 && r <= 5));
      end
    end
    vectors++;
    if (done_rel !== 6 || done_err !== 1'b0 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL basic_done got rel=%0d err=%b cnt=%0d want 6/0/1", done_rel, done_err, done_cnt);
    end
  endtask

  task automatic test_wait();
    logic [VL*XW-1:0] v;
    v = rand_vec();
    for (int k = 0; k < 4; k++) v[k*XW +: XW] = XW'(32'hA0 + k);
    do_xfer(32'h1000, 4, v, 0, 2, 3, -1);
    for (int r = 2; r <= 4; r++) begin
      vectors++;
      if (o_en[r] !== 1'b1 || o_addr[r] !== 32'h1004 || o_wdata[r] !== XW'(32'hA0)) begin
        miscompares++;
        $display("FAIL wait_hold rel=%0d got en=%b addr=%h wdata=%h want 1/00001004/a0",
                 r, o_en[r], o_addr[r], o_wdata[r]);
      end
    end
    vectors++;
    if (done_rel !== 8 || done_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_done got rel=%0d err=%b want 8/0", done_rel, done_err);
    end
    vectors++;
    if (obs_data_q != exp_data_q || obs_addr_q != exp_addr_q) begin
      miscompares++;
      $display("FAIL wait_order got %0d beats want %0d", obs_data_q.size(), exp_data_q.size());
    end
  endtask

  task automatic test_no_traffic();
    logic [31:0] bases[2];
    int          lens[2];
    bases[0] = 32'h1000; lens[0] = 0;
    bases[1] = 32'h1002; lens[1] = 4;
    for (int c = 0; c < 2; c++) begin
      do_xfer(bases[c], lens[c], rand_vec(), 0, -1, -1, -1);
      vectors++;
      if (done_rel !== 1 || done_err !== logic'(c == 1) || done_cnt !== 1) begin
        miscompares++;
        $display("FAIL no_traffic_done case=%0d got rel=%0d err=%b cnt=%0d want 1/%0d/1",
                 c, done_rel, done_err, done_cnt, c);
      end
      vectors++;
      if (o_en[1] !== 1'b0 || o_en[2] !== 1'b0 || o_busy[1] !== 1'b0 || obs_addr_q.size() != 0) begin
        miscompares++;
        $display("FAIL no_traffic_bus case=%0d got en=%b busy=%b beats=%0d want 0/0/0",
                 c, o_en[1], o_busy[1], obs_addr_q.size());
      end
    end
  endtask

  task automatic test_wrap();
    do_xfer(32'hFFFF_FFF8, VL, rand_vec(), 0, -1, -1, -1);
    vectors++;
    if (obs_addr_q.size() != VL || obs_addr_q != exp_addr_q || obs_data_q != exp_data_q) begin
      miscompares++;
      $display("FAIL wrap_beats got %0d beats want %0d matching", obs_addr_q.size(), VL);
    end
    vectors++;
    if (obs_addr_q.size() < 3 || obs_addr_q[2] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_zero got %h want 00000000", obs_addr_q.size() < 3 ? 32'hx : obs_addr_q[2]);
    end
    vectors++;
    if (done_err !== 1'b0 || done_rel !== VL + 2) begin
      miscompares++;
      $display("FAIL wrap_done got rel=%0d err=%b want %0d/0", done_rel, done_err, VL + 2);
    end
  endtask

  task automatic test_ignore_start();
    do_xfer({$urandom_range(0, 1023), 2'b00}, 6, rand_vec(), 0, -1, -1, 2);
    vectors++;
    if (obs_addr_q != exp_addr_q || obs_data_q != exp_data_q) begin
      miscompares++;
      $display("FAIL ignore_start got %0d beats want %0d captured beats", obs_addr_q.size(), exp_addr_q.size());
    end
    vectors++;
    if (done_cnt !== 1 || done_rel !== 8) begin
      miscompares++;
      $display("FAIL ignore_start_done got rel=%0d cnt=%0d want 8/1", done_rel, done_cnt);
    end
  endtask

  task automatic test_abort_reset();
    int seen_done;
    seen_done = 0;
    start = 1'b1; base_addr = 32'h2000; vl = VW'(VL); vec_data = rand_vec();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, err, dmem_en, dmem_wen} !== 5'b0 || dmem_addr !== 32'h0 || dmem_wdata !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs got flags=%b addr=%h wdata=%h want 0",
               {busy, done, err, dmem_en, dmem_wen}, dmem_addr, dmem_wdata);
    end
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      if (done || dmem_en) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin
      miscompares++;
      $display("FAIL abort_quiet got %0d active cycles want 0", seen_done);
    end
    @(posedge clk); #1;
    do_xfer(32'h3000, 3, rand_vec(), 0, -1, -1, -1);
    vectors++;
    if (obs_data_q != exp_data_q || obs_addr_q != exp_addr_q || done_rel !== 5) begin
      miscompares++;
      $display("FAIL abort_restart got beats=%0d done=%0d want 3/5", obs_data_q.size(), done_rel);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a;
    logic        exp_e, exp_d;
    for (int rel = 0; rel <= 11; rel++) begin
      start = (rel == 0) || (rel == 4);
      if (rel == 0) begin base_addr = 32'h4000; vl = VW'(2); vec_data = rand_vec(); end
      if (rel == 4) begin base_addr = 32'h5000; vl = VW'(3); vec_data = rand_vec(); end
      @(negedge clk);
      exp_e = (rel == 1) || (rel == 2) || (rel >= 5 && rel <= 7);
      exp_d = (rel == 4) || (rel == 9);
      exp_a = (rel <= 2) ? 32'h4000 + 32'(4 * (rel - 1)) : 32'h5000 + 32'(4 * (rel - 5));
      vectors++;
      if (done !== exp_d || (done && busy) || dmem_en !== exp_e || (exp_e && dmem_addr !== exp_a)) begin
        miscompares++;
        $display("FAIL b2b rel=%0d got done=%b busy=%b en=%b addr=%h want done=%b en=%b addr=%h",
                 rel, done, busy, dmem_en, dmem_addr, exp_d, exp_e, exp_a);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] b;
    int          n;
    for (int it = 0; it < 24; it++) begin
      b = $urandom;
      if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
      n = $urandom_range(0, VL);
      do_xfer(b, n, rand_vec(), 25, -1, -1, -1);
      vectors++;
      if (obs_addr_q != exp_addr_q || obs_data_q != exp_data_q) begin
        miscompares++;
        $display("FAIL rand_beats it=%0d got %0d beats want %0d", it, obs_addr_q.size(), exp_addr_q.size());
      end
      vectors++;
      if (done_rel !== exp_done_rel || done_cnt !== 1 || done_err !== logic'(b[1:0] != 0 && n != 0)) begin
        miscompares++;
        $display("FAIL rand_done it=%0d got rel=%0d cnt=%0d err=%b want %0d/1/%b",
                 it, done_rel, done_cnt, done_err, exp_done_rel, (b[1:0] != 0 && n != 0));
      end
      vectors++;
      if (overlap_cnt != 0 || port_bad != 0) begin
        miscompares++;
        $display("FAIL rand_port it=%0d got overlap=%0d port_bad=%0d want 0/0", it, overlap_cnt, port_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_no_traffic();
    test_wrap();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
